// File: rtl/datain_handshake_fifo.sv
// datain_handshake_fifo
// Accepts bytes from an asynchronous producer over a four-phase strobe/ack
// handshake. Bytes are buffered in a small FIFO, and the head is presented to
// the CPU data-input PIO. The CPU pops a byte with a rising edge on rd_ack.
module datain_handshake_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_WIDTH-1:0]         ext_data,
  input  logic                          ext_strobe,
  output logic                          ext_ack,
  input  logic                          rd_ack,
  input  logic                          clear_err,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t                  state_reg;
  logic                    ext_ack_reg;
  logic [SYNC_STAGES-1:0]  sync_reg;
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [LVL_W-1:0]        level_reg;
  logic [LVL_W-1:0]        level_next;
  logic                    rd_ack_d_reg;
  logic                    err_reg;
  logic                    err_next;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];

  logic strobe_s;
  logic full;
  logic empty;
  logic push;
  logic pop_evt;
  logic pop;
  logic underflow;

  // The full test only looks at the registered level, so a pop in this cycle
  // cannot make room for a push until the following cycle.
  assign strobe_s  = sync_reg[SYNC_STAGES-1];
  assign full      = (level_reg == FULL_LVL);
  assign empty     = (level_reg == '0);
  assign push      = (state_reg == ST_IDLE) && strobe_s && !full;
  assign pop_evt   = rd_ack && !rd_ack_d_reg;
  assign pop       = pop_evt && !empty;
  assign underflow = pop_evt && empty;

  // Strobe synchronizer. ext_data is not synchronized because the producer
  // holds it stable for the whole handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], ext_strobe};
    end
  end

  // Producer handshake FSM. A byte is written on the IDLE->ACK transition.
  // The write pointer advances on that same transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      ext_ack_reg <= 1'b0;
      wr_ptr_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (push) begin
            state_reg   <= ST_ACK;
            ext_ack_reg <= 1'b1;
            wr_ptr_reg  <= wr_ptr_reg + PTR_W'(1);
          end
        end
        ST_ACK: begin
          if (!strobe_s) begin
            state_reg   <= ST_IDLE;
            ext_ack_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          ext_ack_reg <= 1'b0;
        end
      endcase
    end
  end

  // Next level and next error flag. When an error set and a clear happen in
  // the same cycle, the set takes priority.
  always_comb begin
    level_next = level_reg;
    if (push && !pop) begin
      level_next = level_reg + LVL_W'(1);
    end else if (pop && !push) begin
      level_next = level_reg - LVL_W'(1);
    end
    err_next = err_reg;
    if (underflow) begin
      err_next = 1'b1;
    end else if (clear_err) begin
      err_next = 1'b0;
    end
  end

  // Consumer side: rd_ack edge detect, read pointer, level counter, error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ack_d_reg <= 1'b0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      rd_ack_d_reg <= rd_ack;
      level_reg    <= level_next;
      err_reg      <= err_next;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  // Storage array. It has no reset because its contents are never observed
  // while the level is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= ext_data;
    end
  end

  // Outputs are decoded from registered state only. The head is forced to
  // zero when the FIFO is empty.
  assign ext_ack       = ext_ack_reg;
  assign data_out      = empty ? '0 : mem[rd_ptr_reg];
  assign data_valid    = !empty;
  assign fifo_level    = level_reg;
  assign err_underflow = err_reg;

endmodule
